// File: rtl/boot_mem_responder_pkg.sv
// Shared types and constants for the boot memory responder.
package boot_mem_responder_pkg;

    // Responder mode: loading the image, or serving the core.
    typedef enum logic {
        StBoot = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic [31:0] DefaultIoAddr = 32'h0000_FFFC;
    localparam int unsigned BytesPerWord  = 4;
    // The shift register only needs the bytes that precede the final one of a word.
    localparam int unsigned SrBits        = 8 * (BytesPerWord - 1);

endpackage

// File: rtl/boot_mem_responder_if.sv
// Core memory bus plus loader byte stream, as seen between requester and responder.
interface boot_mem_responder_if;

    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;

    modport master (
        output adr, writedata, memwrite, ld_valid, ld_byte, ld_last,
        input  readdata, ld_ready
    );

    modport slave (
        input  adr, writedata, memwrite, ld_valid, ld_byte, ld_last,
        output readdata, ld_ready
    );

endinterface

// File: rtl/boot_mem_responder_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; a last byte flushes a
// partial word with the missing low-order bytes zero-filled.
module boot_mem_responder_byte_packer
    import boot_mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ld_byte,
    input  logic        accept,
    input  logic        last,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int unsigned CntW = $clog2(BytesPerWord);
    localparam logic [CntW-1:0] LastIdx = CntW'(BytesPerWord - 1);

    logic [SrBits-1:0] sr_q;
    logic [CntW-1:0]   cnt_q;

    assign word_valid = accept & (last | (cnt_q == LastIdx));

    // Assemble the word from the held bytes plus the incoming byte.
    always_comb begin
        word = {sr_q, ld_byte};
        case (cnt_q)
            2'd0:    word = {ld_byte, 24'h00_0000};
            2'd1:    word = {sr_q[7:0], ld_byte, 16'h0000};
            2'd2:    word = {sr_q[15:0], ld_byte, 8'h00};
            default: word = {sr_q, ld_byte};
        endcase
    end

    // Shift accepted bytes in; restart the count whenever a word is emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            sr_q  <= {sr_q[SrBits-9:0], ld_byte};
            cnt_q <= word_valid ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/boot_mem_responder.sv
// Memory-side responder for the multicycle core: word RAM, one MMIO output
// register, and a boot loader that fills the RAM while holding the core in reset.
module boot_mem_responder
    import boot_mem_responder_pkg::*;
#(
    parameter int unsigned AW            = 6,
    parameter logic [31:0] IO_ADDR       = DefaultIoAddr,
    parameter bit          LOAD_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    boot_mem_responder_if.slave  bus,
    output logic                 cpu_reset,
    output logic [31:0]          io_out,
    output logic                 io_strobe,
    output logic                 load_err
);

    localparam int unsigned Depth = 2 ** AW;

    state_e          state_q, state_d;
    // One extra bit so a full RAM is distinguishable from wrap-around.
    logic [AW:0]     wptr_q, wptr_d;
    logic [31:0]     mem [Depth];

    logic            accept;
    logic            word_valid;
    logic [31:0]     pk_word;
    logic            is_io;
    logic            run_wr;
    logic            io_wr;
    logic            overflow;
    logic [AW-1:0]   rd_idx;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [31:0]     mem_wdata;

    assign is_io        = (bus.adr == IO_ADDR);
    assign rd_idx       = bus.adr[AW+1:2];
    assign bus.ld_ready = (state_q == StBoot) & ~reset;
    assign accept       = bus.ld_valid & bus.ld_ready;
    assign cpu_reset    = reset | (state_q != StRun);
    assign run_wr       = (state_q == StRun) & bus.memwrite & ~reset;
    assign io_wr        = run_wr & is_io;
    assign overflow     = wptr_q[AW];
    assign bus.readdata = is_io ? io_out : mem[rd_idx];

    boot_mem_responder_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .ld_byte    (bus.ld_byte),
        .accept     (accept),
        .last       (bus.ld_last),
        .word       (pk_word),
        .word_valid (word_valid)
    );

    // Next state, write pointer and the single RAM write port (loader or core).
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        mem_we    = 1'b0;
        mem_waddr = rd_idx;
        mem_wdata = bus.writedata;
        if (word_valid) begin
            if (!overflow) begin
                mem_we    = 1'b1;
                mem_waddr = wptr_q[AW-1:0];
                mem_wdata = pk_word;
                wptr_d    = wptr_q + (AW+1)'(1);
            end
        end else if (run_wr && !is_io) begin
            mem_we = 1'b1;
        end
        if (accept && bus.ld_last) begin
            state_d = StRun;
        end
    end

    // Control state, MMIO register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD_ON_RESET ? StBoot : StRun;
            wptr_q    <= '0;
            io_out    <= '0;
            io_strobe <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            io_strobe <= io_wr;
            if (io_wr) begin
                io_out <= bus.writedata;
            end
            if (word_valid && overflow) begin
                load_err <= 1'b1;
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
